// File: rtl/seq_detect_pkg.sv
// Shared definitions for the parametrised serial pattern detector.
// Holds the default pattern length, counter width and reset-time pattern,
// plus the helper that sizes the window fill counter.
package seq_detect_pkg;

  localparam int PAT_LEN_DEF = 4;
  localparam int CNT_W_DEF   = 8;

  // MSB is the first bit received.
  localparam logic [PAT_LEN_DEF-1:0] PATTERN_DEF = 4'b1011;

  // Fill counter must hold 0..len inclusive.
  function automatic int fill_w(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Saturating match counter.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   inc        : count one match this edge
//   clear      : zero the counter this edge (applied before inc)
//   cnt        : current count, saturates at 2^CNT_W-1
//   sat        : cnt is at its maximum (registered with cnt)
module seq_match_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] base;
  logic [CNT_W-1:0] cnt_nxt;

  // Clear first, then count, so clear+match on one edge yields 1.
  always_comb begin
    base    = clear ? '0 : cnt;
    cnt_nxt = base;
    if (inc && (base != CNT_MAX)) begin
      cnt_nxt = base + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      sat <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      sat <= (cnt_nxt == CNT_MAX);
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector.
// Shifts accepted bits into a PAT_LEN-bit window and pulses seq_seen the
// cycle after the bit that completes a match. Pattern is reloadable and
// detection can be overlapping or non-overlapping.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   inp_bit     : serial data, consumed when inp_valid = 1
//   inp_valid   : input bit qualifier
//   overlap_en  : 1 = overlapping, 0 = non-overlapping detection
//   pat_load    : load pat_in as the pattern (clears window, drops bit)
//   pat_in      : new pattern, MSB first
//   cnt_clear   : zero the match counter
//   seq_seen    : one-cycle match pulse
//   match_count : saturating match count
//   count_sat   : match_count at maximum
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int                 PAT_LEN = PAT_LEN_DEF,
  parameter logic [PAT_LEN-1:0] PATTERN = PATTERN_DEF,
  parameter int                 CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inp_bit,
  input  logic               inp_valid,
  input  logic               overlap_en,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               cnt_clear,
  output logic               seq_seen,
  output logic [CNT_W-1:0]   match_count,
  output logic               count_sat
);

  localparam int                FILL_W    = fill_w(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

  logic [PAT_LEN-1:0] pat_p0;
  logic [PAT_LEN-1:0] hist_p0;
  logic [FILL_W-1:0]  fill_p0;

  logic [PAT_LEN-1:0] hist_nxt;
  logic [FILL_W-1:0]  fill_inc;
  logic               match;

  // Match is judged on the window as it will be after this bit shifts in.
  // Gating by inp_valid first keeps an X on inp_bit out of match.
  always_comb begin
    hist_nxt = {hist_p0[PAT_LEN-2:0], inp_bit};
    fill_inc = (fill_p0 == FILL_FULL) ? FILL_FULL : fill_p0 + 1'b1;
    match    = inp_valid && !pat_load &&
               (fill_inc == FILL_FULL) && (hist_nxt == pat_p0);
  end

  // Stage p0: window, fill and pattern registers; registered match pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_p0   <= PATTERN;
      hist_p0  <= '0;
      fill_p0  <= '0;
      seq_seen <= 1'b0;
    end else if (pat_load) begin
      pat_p0   <= pat_in;
      hist_p0  <= '0;
      fill_p0  <= '0;
      seq_seen <= 1'b0;
    end else begin
      seq_seen <= match;
      if (inp_valid) begin
        hist_p0 <= hist_nxt;
        // Non-overlap: restart the fill so the next match needs fresh bits.
        fill_p0 <= (match && !overlap_en) ? '0 : fill_inc;
      end
    end
  end

  // A pattern load leaves the counter untouched, including a pending clear.
  seq_match_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (match),
    .clear (cnt_clear && !pat_load),
    .cnt   (match_count),
    .sat   (count_sat)
  );

endmodule

// File: tb/tb_seq_detect_param.sv
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       inp_bit = 1'b0;
  logic       inp_valid = 1'b0;
  logic       overlap_en = 1'b0;
  logic       pat_load = 1'b0;
  logic [3:0] pat_in = 4'b0000;
  logic       cnt_clear = 1'b0;

  logic       seq_seen;
  logic [7:0] match_count;
  logic       count_sat;

  logic       s_seq_seen;
  logic [1:0] s_match_count;
  logic       s_count_sat;

  integer n_cmp = 0;
  integer n_bad = 0;

  always #5 clk = ~clk;

  seq_detect_param dut (
    .clk         (clk),
    .reset       (reset),
    .inp_bit     (inp_bit),
    .inp_valid   (inp_valid),
    .overlap_en  (overlap_en),
    .pat_load    (pat_load),
    .pat_in      (pat_in),
    .cnt_clear   (cnt_clear),
    .seq_seen    (seq_seen),
    .match_count (match_count),
    .count_sat   (count_sat)
  );

  seq_detect_param #(.CNT_W(2)) dut_sat (
    .clk         (clk),
    .reset       (reset),
    .inp_bit     (inp_bit),
    .inp_valid   (inp_valid),
    .overlap_en  (overlap_en),
    .pat_load    (pat_load),
    .pat_in      (pat_in),
    .cnt_clear   (cnt_clear),
    .seq_seen    (s_seq_seen),
    .match_count (s_match_count),
    .count_sat   (s_count_sat)
  );

  // Drive one cycle of stimulus on the falling edge, return just after the rising edge.
  task automatic drive(input logic b, input logic v);
    @(negedge clk);
    inp_bit   = b;
    inp_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    inp_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp = n_cmp + 1;
    if (seq_seen !== 1'b0) begin
      n_bad = n_bad + 1; $display("FAIL reset_seq_seen got %b want 0", seq_seen);
    end
    n_cmp = n_cmp + 1;
    if (match_count !== 8'd0) begin
      n_bad = n_bad + 1; $display("FAIL reset_count got %0d want 0", match_count);
    end
    n_cmp = n_cmp + 1;
    if (count_sat !== 1'b0 || s_count_sat !== 1'b0) begin
      n_bad = n_bad + 1; $display("FAIL reset_sat got %b/%b want 0/0", count_sat, s_count_sat);
    end
  endtask

  task automatic run_stream7(input string name, input logic ov, input logic [6:0] exp,
                             input logic [7:0] exp_cnt);
    logic [6:0] stream;
    stream = 7'b1011011;
    do_reset();
    overlap_en = ov;
    for (int i = 0; i < 7; i++) begin
      drive(stream[6-i], 1'b1);
      n_cmp = n_cmp + 1;
      if (seq_seen !== exp[6-i]) begin
        n_bad = n_bad + 1;
        $display("FAIL %s_pulse bit%0d got %b want %b", name, i + 1, seq_seen, exp[6-i]);
      end
    end
    drive(1'b0, 1'b0);
    n_cmp = n_cmp + 1;
    if (match_count !== exp_cnt) begin
      n_bad = n_bad + 1;
      $display("FAIL %s_count got %0d want %0d", name, match_count, exp_cnt);
    end
  endtask

  task automatic test_non_overlap();
    run_stream7("nonovl", 1'b0, 7'b0001000, 8'd1);
  endtask

  task automatic test_overlap();
    run_stream7("ovl", 1'b1, 7'b0001001, 8'd2);
  endtask

  task automatic test_valid_gaps();
    logic [3:0] pat;
    pat = 4'b1011;
    do_reset();
    overlap_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(pat[3-i], 1'b1);
      n_cmp = n_cmp + 1;
      if (seq_seen !== (i == 3)) begin
        n_bad = n_bad + 1;
        $display("FAIL gaps_pulse bit%0d got %b want %b", i + 1, seq_seen, (i == 3));
      end
      for (int g = 0; g < 3; g++) begin
        drive(1'($urandom_range(0, 1)), 1'b0);
        n_cmp = n_cmp + 1;
        if (seq_seen !== 1'b0) begin
          n_bad = n_bad + 1;
          $display("FAIL gaps_idle bit%0d gap%0d got %b want 0", i + 1, g, seq_seen);
        end
      end
    end
    n_cmp = n_cmp + 1;
    if (match_count !== 8'd1) begin
      n_bad = n_bad + 1; $display("FAIL gaps_count got %0d want 1", match_count);
    end
  endtask

  task automatic test_pat_reload();
    logic [3:0] a;
    logic [3:0] b;
    a = 4'b1011;
    b = 4'b0110;
    do_reset();
    overlap_en = 1'b0;
    for (int i = 0; i < 4; i++) drive(a[3-i], 1'b1);
    // Load with a valid bit present: that bit is dropped, no pulse.
    @(negedge clk);
    pat_load  = 1'b1;
    pat_in    = 4'b0110;
    inp_bit   = 1'b1;
    inp_valid = 1'b1;
    @(posedge clk);
    #1;
    pat_load = 1'b0;
    n_cmp = n_cmp + 1;
    if (seq_seen !== 1'b0) begin
      n_bad = n_bad + 1; $display("FAIL load_pulse got %b want 0", seq_seen);
    end
    n_cmp = n_cmp + 1;
    if (match_count !== 8'd1) begin
      n_bad = n_bad + 1; $display("FAIL load_count got %0d want 1", match_count);
    end
    for (int i = 0; i < 4; i++) begin
      drive(b[3-i], 1'b1);
      n_cmp = n_cmp + 1;
      if (seq_seen !== (i == 3)) begin
        n_bad = n_bad + 1;
        $display("FAIL newpat_pulse bit%0d got %b want %b", i + 1, seq_seen, (i == 3));
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive(a[3-i], 1'b1);
      n_cmp = n_cmp + 1;
      if (seq_seen !== 1'b0) begin
        n_bad = n_bad + 1;
        $display("FAIL oldpat_pulse bit%0d got %b want 0", i + 1, seq_seen);
      end
    end
    n_cmp = n_cmp + 1;
    if (match_count !== 8'd2) begin
      n_bad = n_bad + 1; $display("FAIL reload_count got %0d want 2", match_count);
    end
  endtask

  task automatic test_saturation();
    logic [3:0] a;
    logic [1:0] exp_c;
    a = 4'b1011;
    do_reset();
    overlap_en = 1'b1;
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 4; i++) drive(a[3-i], 1'b1);
      exp_c = (r >= 2) ? 2'd3 : 2'(r + 1);
      n_cmp = n_cmp + 1;
      if (s_match_count !== exp_c || s_count_sat !== (r >= 2)) begin
        n_bad = n_bad + 1;
        $display("FAIL sat_count rep%0d got %0d/%b want %0d/%b", r, s_match_count, s_count_sat,
                 exp_c, (r >= 2));
      end
    end
    for (int i = 0; i < 3; i++) drive(a[3-i], 1'b1);
    @(negedge clk);
    cnt_clear = 1'b1;
    inp_bit   = 1'b1;
    inp_valid = 1'b1;
    @(posedge clk);
    #1;
    cnt_clear = 1'b0;
    n_cmp = n_cmp + 1;
    if (s_match_count !== 2'd1 || s_count_sat !== 1'b0 || s_seq_seen !== 1'b1) begin
      n_bad = n_bad + 1;
      $display("FAIL clear_match got cnt=%0d sat=%b seen=%b want 1/0/1", s_match_count,
               s_count_sat, s_seq_seen);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] a;
    logic [3:0] exp;
    a = 4'b1011;
    exp = 4'b0001;
    do_reset();
    overlap_en = 1'b0;
    // Load a different pattern so a later 1011 match proves the reset default returned.
    @(negedge clk);
    pat_load = 1'b1;
    pat_in   = 4'b0110;
    @(posedge clk);
    #1;
    pat_load = 1'b0;
    for (int i = 0; i < 3; i++) drive(a[3-i], 1'b1);
    do_reset();
    n_cmp = n_cmp + 1;
    if (seq_seen !== 1'b0) begin
      n_bad = n_bad + 1; $display("FAIL rstmid_reset_pulse got %b want 0", seq_seen);
    end
    drive(1'b1, 1'b1);
    n_cmp = n_cmp + 1;
    if (seq_seen !== 1'b0) begin
      n_bad = n_bad + 1; $display("FAIL rstmid_after_pulse got %b want 0", seq_seen);
    end
    for (int i = 0; i < 4; i++) begin
      drive(a[3-i], 1'b1);
      n_cmp = n_cmp + 1;
      if (seq_seen !== exp[3-i]) begin
        n_bad = n_bad + 1;
        $display("FAIL rstmid_restore bit%0d got %b want %b", i + 1, seq_seen, exp[3-i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp;
    exp = 6'b000111;
    do_reset();
    overlap_en = 1'b1;
    @(negedge clk);
    pat_load = 1'b1;
    pat_in   = 4'b1111;
    @(posedge clk);
    #1;
    pat_load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1);
      n_cmp = n_cmp + 1;
      if (seq_seen !== exp[5-i]) begin
        n_bad = n_bad + 1;
        $display("FAIL b2b_pulse bit%0d got %b want %b", i + 1, seq_seen, exp[5-i]);
      end
    end
    n_cmp = n_cmp + 1;
    if (match_count !== 8'd3) begin
      n_bad = n_bad + 1; $display("FAIL b2b_count got %0d want 3", match_count);
    end
  endtask

  initial begin
    test_reset();
    test_non_overlap();
    test_overlap();
    test_valid_gaps();
    test_pat_reload();
    test_saturation();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised serial pattern detector; successor to the fixed 4-bit detector.
- Matches a PAT_LEN-bit pattern on a serial bit stream qualified by a valid strobe.
- Pattern is a parameter default and can be reloaded at runtime; overlapping or non-overlapping detection is selected at runtime.
- Keeps a saturating match counter for status/debug; sits between the serial front end and the status register block.

Parameters:
- PAT_LEN, 4, pattern length in bits (2..32).
- PATTERN, 4'b1011, reset-time pattern; MSB is the first bit received.
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- inp_bit  input  1  serial data bit.
- inp_valid  input  1  inp_bit is consumed on an edge where this is 1; otherwise inp_bit is ignored.
- overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping.
- pat_load  input  1  load pat_in as the new pattern.
- pat_in  input  PAT_LEN  new pattern, MSB first.
- cnt_clear  input  1  zero the match counter.
- seq_seen  output  1  one-cycle match pulse.
- match_count  output  CNT_W  number of matches, saturating.
- count_sat  output  1  match_count is at its maximum.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset: pattern register = PATTERN, history = 0, fill = 0, seq_seen = 0, match_count = 0, count_sat = 0.
- History: a PAT_LEN-bit shift register. On an accepted bit, history <= {history[PAT_LEN-2:0], inp_bit}.
- Fill counter: 0..PAT_LEN, incremented on each accepted bit and saturating at PAT_LEN. A bit does not count until the window is full.
- Match condition on an accepted bit, evaluated on the shifted-in value: the new history equals the pattern register and the new fill equals PAT_LEN.
- seq_seen: registered. High for exactly one cycle, on the cycle after the edge that accepted the completing bit; otherwise 0.
- Back-to-back matches produce consecutive seq_seen pulses with no dead cycle.
- Overlap mode, overlap_en = 1: fill is left at PAT_LEN after a match, so the trailing bits can start the next match.
- Non-overlap mode, overlap_en = 0: on a match, fill is set to 0 in the same edge. The history is still shifted, but the next match needs PAT_LEN fresh bits.
- overlap_en is sampled per accepted bit. Changing it mid-stream affects only the next match decision.
- pat_load has priority over everything except reset:
  - pattern <= pat_in, history <= 0, fill <= 0;
  - inp_bit is dropped that cycle;
  - no match is evaluated and seq_seen is 0 next cycle;
  - match_count is unchanged.
- Match counter:
  - increments by 1 on each match, saturating at 2^CNT_W - 1;
  - count_sat = (match_count == max), registered together with match_count;
  - cnt_clear zeroes the counter. If cnt_clear and a match occur on the same edge, the result is 1 (clear, then count); seq_seen still pulses.
- Reset mid-sequence: partial history is discarded and no pulse follows; the pattern reverts to PATTERN.
- inp_valid = 0: history, fill and the counter hold, and seq_seen = 0 next cycle.
- Widths: fill uses $clog2(PAT_LEN+1) bits. The counter compare is unsigned. No X is propagated from inp_bit while inp_valid = 0.

Decomposition:
- Shared package seq_detect_pkg holds:
  - default PAT_LEN and CNT_W;
  - the default PATTERN constant;
  - a localparam function for the fill-counter width.
- One sub-module, seq_match_counter: parametrised CNT_W saturating counter with inc, clear (clear-then-inc on the same edge) and sat flag.
- Shift/compare and control stay in the top module.

Test Plan:
- Non-overlap, defaults, inp_valid always 1, stream 1,0,1,1,0,1,1 -> exactly one seq_seen pulse, in the cycle after bit 4; match_count = 1.
- Overlap_en = 1, same stream -> pulses after bit 4 and after bit 7; match_count = 2.
- Valid gaps: pattern 1011 delivered with inp_valid = 0 for 3 cycles between each bit (inp_bit toggling randomly during the gaps) -> exactly one pulse, one cycle after the 4th valid bit.
- Pattern reload: pat_load with pat_in = 4'b0110, asserted together with a valid bit, then stream 0,1,1,0 -> no pulse on the load cycle; one pulse after the final 0; the old pattern 1011 no longer matches.
- Saturation with CNT_W = 2, overlap mode, stream 1,0,1,1 repeated 5 times -> match_count stops at 3 with count_sat = 1. Then cnt_clear together with a match -> match_count = 1, count_sat = 0.
- Reset mid-sequence: send 1,0,1, assert reset for 1 cycle, then send 1 -> no pulse. A subsequent full 1,0,1,1 -> one pulse, confirming the pattern was restored to PATTERN.
